// File: rtl/clint_pkg.sv
// clint_pkg: shared states, CSR addresses, instruction encodings and mstatus helpers for clint_arb
package clint_pkg;
  typedef enum logic [2:0] {IDLE, W_MEPC, W_MCAUSE, W_MSTATUS, W_MSTATUS_MRET, ASSERT} state_t;
  localparam logic [11:0] CSR_MSTATUS = 12'h300;
  localparam logic [11:0] CSR_MEPC = 12'h341;
  localparam logic [11:0] CSR_MCAUSE = 12'h342;
  localparam logic [31:0] INST_ECALL = 32'h0000_0073;
  localparam logic [31:0] INST_EBREAK = 32'h0010_0073;
  localparam logic [31:0] INST_MRET = 32'h3020_0073;
  localparam logic [31:0] CAUSE_EBREAK = 32'd3;
  localparam logic [31:0] CAUSE_ECALL = 32'd11;
  localparam int MIE_BIT = 3;
  localparam int MPIE_BIT = 7;
  // trap entry: stash MIE into MPIE and disable interrupts
  function automatic logic [31:0] trap_mstatus(input logic [31:0] s);
    logic [31:0] r;
    r = s;
    r[MPIE_BIT] = s[MIE_BIT];
    r[MIE_BIT] = 1'b0;
    return r;
  endfunction
  // trap return: restore MIE from MPIE and set MPIE
  function automatic logic [31:0] mret_mstatus(input logic [31:0] s);
    logic [31:0] r;
    r = s;
    r[MIE_BIT] = s[MPIE_BIT];
    r[MPIE_BIT] = 1'b1;
    return r;
  endfunction
endpackage

// File: rtl/clint_arb_irq_prio_enc.sv
// irq_prio_enc: lowest-index-wins priority encoder over the active interrupt lines
module irq_prio_enc
  import clint_pkg::*;
#(
  parameter int NUM_IRQ = 8,
  localparam int IW = NUM_IRQ > 1 ? $clog2(NUM_IRQ) : 1
) (
  input  logic [NUM_IRQ-1:0] req,
  output logic               valid,
  output logic [IW-1:0]      idx,
  output logic [NUM_IRQ-1:0] onehot
);
  assign valid = |req;
  assign onehot = req & (~req + NUM_IRQ'(1));
  // scan downwards so the lowest active line is the last one written
  always_comb begin
    idx = '0;
    for (int i = NUM_IRQ - 1; i >= 0; i--) idx = req[i] ? IW'(i) : idx;
  end
endmodule

// File: rtl/clint_arb.sv
// clint_arb: trap/interrupt arbiter sequencing mepc/mcause/mstatus writes then a PC redirect (option: CLINT_VECTORED_EN)
module clint_arb
  import clint_pkg::*;
#(
  parameter int NUM_IRQ = 8,
  parameter int IRQ_CAUSE_BASE = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_IRQ-1:0] irq_i,
  input  logic [NUM_IRQ-1:0] irq_en_i,
  input  logic               global_int_en_i,
  input  logic [31:0]        inst_i,
  input  logic [31:0]        inst_addr_i,
  input  logic               jump_flag_i,
  input  logic [31:0]        jump_addr_i,
  input  logic               hold_flag_i,
  input  logic [31:0]        csr_mtvec_i,
  input  logic [31:0]        csr_mepc_i,
  input  logic [31:0]        csr_mstatus_i,
  output logic               hold_flag_o,
  output logic               csr_we_o,
  output logic [11:0]        csr_waddr_o,
  output logic [31:0]        csr_wdata_o,
  output logic               int_assert_o,
  output logic [31:0]        int_addr_o,
  output logic [NUM_IRQ-1:0] irq_ack_o
);
  localparam int IW = NUM_IRQ > 1 ? $clog2(NUM_IRQ) : 1;
  state_t state, state_d;
  logic irq_valid, is_ecall, is_ebreak, is_mret, irq_take, accept, req_async;
  logic [IW-1:0] irq_idx;
  logic [NUM_IRQ-1:0] irq_onehot, onehot_q, ack_d;
  logic [31:0] req_pc, req_cause, pc_q, cause_q, base, vec_addr, wdata_d, addr_d;
  logic [11:0] waddr_d;
  logic async_q, mret_q, we_d, assert_d, unused_mtvec_mode;
  irq_prio_enc #(.NUM_IRQ(NUM_IRQ)) u_enc (
    .req(irq_i & irq_en_i),
    .valid(irq_valid),
    .idx(irq_idx),
    .onehot(irq_onehot)
  );
  assign is_ecall = inst_i == INST_ECALL;
  assign is_ebreak = inst_i == INST_EBREAK;
  assign is_mret = inst_i == INST_MRET;
  assign irq_take = irq_valid && global_int_en_i && !hold_flag_i;
  assign accept = state == IDLE && (is_ecall || is_ebreak || is_mret || irq_take);
  assign req_async = !(is_ecall || is_ebreak || is_mret);
  assign req_pc = req_async && jump_flag_i ? jump_addr_i : inst_addr_i;
  assign req_cause = is_ecall ? CAUSE_ECALL : is_ebreak ? CAUSE_EBREAK : is_mret ? '0 :
                     32'h8000_0000 | (32'(IRQ_CAUSE_BASE) + 32'(irq_idx));
  assign hold_flag_o = state != IDLE || accept;
  assign base = {csr_mtvec_i[31:2], 2'b00};
  assign unused_mtvec_mode = ^csr_mtvec_i[1:0];
`ifdef CLINT_VECTORED_EN
  assign vec_addr = async_q && csr_mtvec_i[1:0] == 2'b01 ? base + {cause_q[29:0], 2'b00} : base;
`else
  assign vec_addr = base;
`endif
  // next state and the output values that state will present, so outputs come straight from flops
  always_comb begin
    state_d = state == IDLE ? (!accept ? IDLE : is_mret ? W_MSTATUS_MRET : W_MEPC) :
              state == W_MEPC ? W_MCAUSE :
              state == W_MCAUSE ? W_MSTATUS :
              state == W_MSTATUS || state == W_MSTATUS_MRET ? ASSERT : IDLE;
    we_d = state_d == W_MEPC || state_d == W_MCAUSE || state_d == W_MSTATUS || state_d == W_MSTATUS_MRET;
    waddr_d = state_d == W_MEPC ? CSR_MEPC : state_d == W_MCAUSE ? CSR_MCAUSE : we_d ? CSR_MSTATUS : '0;
    wdata_d = state_d == W_MEPC ? req_pc :
              state_d == W_MCAUSE ? cause_q :
              state_d == W_MSTATUS ? trap_mstatus(csr_mstatus_i) :
              state_d == W_MSTATUS_MRET ? mret_mstatus(csr_mstatus_i) : '0;
    assert_d = state_d == ASSERT;
    addr_d = !assert_d ? '0 : mret_q ? csr_mepc_i : vec_addr;
    ack_d = assert_d && async_q ? onehot_q : '0;
  end
  // state, captured request and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      pc_q <= '0;
      cause_q <= '0;
      async_q <= 1'b0;
      mret_q <= 1'b0;
      onehot_q <= '0;
      csr_we_o <= 1'b0;
      csr_waddr_o <= '0;
      csr_wdata_o <= '0;
      int_assert_o <= 1'b0;
      int_addr_o <= '0;
      irq_ack_o <= '0;
    end else begin
      state <= state_d;
      csr_we_o <= we_d;
      csr_waddr_o <= waddr_d;
      csr_wdata_o <= wdata_d;
      int_assert_o <= assert_d;
      int_addr_o <= addr_d;
      irq_ack_o <= ack_d;
      if (accept) begin
        pc_q <= req_pc;
        cause_q <= req_cause;
        async_q <= req_async;
        mret_q <= is_mret;
        onehot_q <= req_async ? irq_onehot : '0;
      end
    end
  end
endmodule

// File: tb/tb_clint_arb.sv
// tb_clint_arb: directed bench with a scoreboard of expected CSR writes and redirects for clint_arb
module tb_clint_arb;
  typedef logic [85:0] ev_t;
  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam logic [31:0] ECALL = 32'h0000_0073;
  localparam logic [31:0] MRET = 32'h3020_0073;
`ifdef CLINT_VECTORED_EN
  localparam logic [31:0] VEC0 = 32'h240;
`else
  localparam logic [31:0] VEC0 = 32'h200;
`endif
  logic clk = 1'b0, rst = 1'b1;
  logic [7:0] irq_i, irq_en_i, irq_ack_o;
  logic global_int_en_i, jump_flag_i, hold_flag_i;
  logic [31:0] inst_i, inst_addr_i, jump_addr_i, csr_mtvec_i, csr_mepc_i, csr_mstatus_i;
  logic hold_flag_o, csr_we_o, int_assert_o;
  logic [11:0] csr_waddr_o;
  logic [31:0] csr_wdata_o, int_addr_o;
  ev_t sb[$];
  int n_cmp = 0, n_bad = 0;
  clint_arb #(.NUM_IRQ(8), .IRQ_CAUSE_BASE(16)) dut (
    .clk(clk), .rst(rst), .irq_i(irq_i), .irq_en_i(irq_en_i),
    .global_int_en_i(global_int_en_i), .inst_i(inst_i), .inst_addr_i(inst_addr_i),
    .jump_flag_i(jump_flag_i), .jump_addr_i(jump_addr_i), .hold_flag_i(hold_flag_i),
    .csr_mtvec_i(csr_mtvec_i), .csr_mepc_i(csr_mepc_i), .csr_mstatus_i(csr_mstatus_i),
    .hold_flag_o(hold_flag_o), .csr_we_o(csr_we_o), .csr_waddr_o(csr_waddr_o),
    .csr_wdata_o(csr_wdata_o), .int_assert_o(int_assert_o), .int_addr_o(int_addr_o),
    .irq_ack_o(irq_ack_o)
  );
  always #5 clk = ~clk;
  function automatic ev_t csr_ev(input logic [11:0] a, input logic [31:0] d);
    return {2'b10, a, d, 32'h0, 8'h0};
  endfunction
  function automatic ev_t as_ev(input logic [31:0] a, input logic [7:0] k);
    return {2'b01, 12'h0, 32'h0, a, k};
  endfunction
  task automatic chk(input string tag, input logic [127:0] o, input logic [127:0] e);
    n_cmp++;
    assert (o === e) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
    end
  endtask
  task automatic cyc(input string tag, input logic [2:0] e);
    @(negedge clk);
    chk(tag, {125'b0, hold_flag_o, csr_we_o, int_assert_o}, {125'b0, e});
    @(posedge clk);
    #1;
  endtask
  task automatic zero_chk(input string tag);
    @(negedge clk);
    chk(tag, {41'b0, csr_we_o, int_assert_o, hold_flag_o, irq_ack_o, csr_waddr_o, csr_wdata_o, int_addr_o}, '0);
    @(posedge clk);
    #1;
  endtask
  always @(negedge clk) begin
    ev_t obs, want;
    if (csr_we_o === 1'b1 || int_assert_o === 1'b1) begin
      obs = {csr_we_o, int_assert_o, csr_waddr_o, csr_wdata_o, int_addr_o, irq_ack_o};
      n_cmp++;
      assert (sb.size() != 0) else begin
        n_bad++;
        $error("FAIL sb_unexpected observed=%h expected=none", obs);
      end
      if (sb.size() != 0) begin
        want = sb.pop_front();
        n_cmp++;
        assert (obs === want) else begin
          n_bad++;
          $error("FAIL sb_event observed=%h expected=%h", obs, want);
        end
      end
    end
  end
  initial begin
    inst_i = NOP; inst_addr_i = 0; irq_i = 0; irq_en_i = 8'hFF; global_int_en_i = 1;
    jump_flag_i = 0; jump_addr_i = 0; hold_flag_i = 0;
    csr_mtvec_i = 32'h200; csr_mepc_i = 0; csr_mstatus_i = 32'h8;
    repeat (3) @(posedge clk);
    #1;
    zero_chk("reset_outputs");
    rst = 0;
    inst_addr_i = 32'h100; inst_i = ECALL;
    sb.push_back(csr_ev(12'h341, 32'h100));
    sb.push_back(csr_ev(12'h342, 32'd11));
    sb.push_back(csr_ev(12'h300, 32'h80));
    sb.push_back(as_ev(32'h200, 8'h00));
    cyc("ecall_T0", 3'b100);
    inst_i = NOP;
    cyc("ecall_T1", 3'b110); cyc("ecall_T2", 3'b110); cyc("ecall_T3", 3'b110);
    cyc("ecall_T4", 3'b101); cyc("ecall_T5", 3'b000);
    inst_addr_i = 32'h500; jump_flag_i = 1; jump_addr_i = 32'h400; irq_i = 8'b0000_0110;
    sb.push_back(csr_ev(12'h341, 32'h400));
    sb.push_back(csr_ev(12'h342, 32'h8000_0011));
    sb.push_back(csr_ev(12'h300, 32'h80));
    sb.push_back(as_ev(32'h200, 8'h02));
    cyc("irq_T0", 3'b100);
    irq_i = 0; jump_flag_i = 0;
    cyc("irq_T1", 3'b110); cyc("irq_T2", 3'b110); cyc("irq_T3", 3'b110);
    cyc("irq_T4", 3'b101); cyc("irq_T5", 3'b000);
    csr_mstatus_i = 32'h80; csr_mepc_i = 32'h104; inst_i = MRET;
    sb.push_back(csr_ev(12'h300, 32'h88));
    sb.push_back(as_ev(32'h104, 8'h00));
    cyc("mret_T0", 3'b100);
    inst_i = NOP;
    cyc("mret_T1", 3'b110); cyc("mret_T2", 3'b101); cyc("mret_T3", 3'b000);
    csr_mstatus_i = 32'h8; csr_mtvec_i = 32'h201; inst_addr_i = 32'h100; irq_i = 8'h01; inst_i = ECALL;
    sb.push_back(csr_ev(12'h341, 32'h100));
    sb.push_back(csr_ev(12'h342, 32'd11));
    sb.push_back(csr_ev(12'h300, 32'h80));
    sb.push_back(as_ev(32'h200, 8'h00));
    sb.push_back(csr_ev(12'h341, 32'h100));
    sb.push_back(csr_ev(12'h342, 32'h8000_0010));
    sb.push_back(csr_ev(12'h300, 32'h80));
    sb.push_back(as_ev(VEC0, 8'h01));
    cyc("both_T0", 3'b100);
    inst_i = NOP;
    cyc("both_T1", 3'b110); cyc("both_T2", 3'b110); cyc("both_T3", 3'b110);
    cyc("both_T4", 3'b101); cyc("both_T5", 3'b100);
    irq_i = 0;
    cyc("both_T6", 3'b110); cyc("both_T7", 3'b110); cyc("both_T8", 3'b110);
    cyc("both_T9", 3'b101); cyc("both_T10", 3'b000);
    csr_mtvec_i = 32'h200; irq_i = 8'h01; hold_flag_i = 1;
    cyc("gate_hold0", 3'b000); cyc("gate_hold1", 3'b000);
    hold_flag_i = 0; global_int_en_i = 0;
    cyc("gate_mie0", 3'b000); cyc("gate_mie1", 3'b000);
    global_int_en_i = 1; irq_en_i = 0;
    cyc("gate_en", 3'b000);
    irq_en_i = 8'hFF; irq_i = 0;
    inst_addr_i = 32'h300; inst_i = ECALL;
    sb.push_back(csr_ev(12'h341, 32'h300));
    sb.push_back(csr_ev(12'h342, 32'd11));
    cyc("rst_T0", 3'b100);
    inst_i = NOP;
    cyc("rst_T1", 3'b110);
    rst = 1;
    cyc("rst_T2", 3'b110);
    rst = 0;
    zero_chk("rst_T3_outputs");
    cyc("rst_T4", 3'b000); cyc("rst_T5", 3'b000); cyc("rst_T6", 3'b000);
    chk("sb_drained", 128'(sb.size()), '0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
